exe_issue: RTL and testbench
============================

// Module: exe_issue
// PURPOSE
//  Issue stage between decode and the execute ALU. Buffers decoded operations
//  in a 2-entry FIFO and drives the ALU operand/func/valid inputs. Holds them
//  stable while the ALU raises bubble (multiply/divide), captures the ALU
//  result, and presents it downstream on a valid/ready handshake.
// PARAMETERS
//  FUNC_W  5   width of the ALU function code (alufunc encoding)
//  TAG_W   8   width of the opaque per-op tag carried alongside (pc/rd/id)
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  resetn      in   1       synchronous reset, active low
//  flush       in   1       synchronous kill of all buffered/in-flight ops
//  in_valid    in   1       decode offers an op
//  in_ready    out  1       FIFO can accept (count<2 && resetn)
//  in_a/in_b   in   64      operands
//  in_func     in   FUNC_W  ALU function
//  in_choose   in   1       32-bit (W-suffix) op select
//  in_tag      in   TAG_W   tag
//  alu_a/alu_b out  64      head-entry operands to ALU
//  alu_func    out  FUNC_W  head-entry function
//  alu_choose  out  1       head-entry choose
//  alu_valid   out  1       ALU valid (level); high only in BUSY
//  alu_bubble  in   1       ALU busy; result not yet usable
//  alu_result  in   64      ALU result (already sign-extended for choose)
//  out_valid   out  1       result available
//  out_ready   in   1       downstream accepts
//  out_result  out  64      registered result
//  out_tag     out  TAG_W   tag of the op in out_result
// BEHAVIOUR
//  Reset (resetn=0 at posedge): state=IDLE, FIFO count=0, rd/wr ptr=0,
//   out_valid=0, out_result=0, out_tag=0; alu_valid=0; in_ready=0 while resetn=0.
//  FIFO: 2 entries {a,b,func,choose,tag}; push on in_valid&&in_ready; pop on
//   result capture. Push+pop in one cycle: count unchanged. Ptrs wrap mod 2.
//   in_ready is combinational from current count only (no same-cycle pop credit).
//  alu_* outputs always reflect the FIFO head; they are constant while BUSY.
//  FSM (state advance at posedge):
//   IDLE: alu_valid=0, out_valid=0. count>0 -> BUSY.
//   BUSY: alu_valid=1. If alu_bubble=0: out_result<=alu_result, out_tag<=head tag,
//     pop, -> DONE. Else stay (single-cycle ops and b==0 div/rem finish in the
//     first BUSY cycle).
//   DONE: out_valid=1, out_result/out_tag held. out_ready=1 -> (count>0 ? BUSY
//     : IDLE), count evaluated after this cycle's push. out_ready=0 -> stay.
//  Timing: push at cycle N, FIFO previously empty, IDLE -> BUSY at N+1 ->
//   out_valid at N+2 (1-cycle op). Sustained rate: 1 op per 2 cycles.
//  alu_valid drops to 0 in the cycle after capture (DONE), so the multi/div
//   units see a valid gap between consecutive ops.
//  flush=1 (priority over all but reset): next state IDLE, count=0, ptrs=0,
//   out_valid=0; same-cycle push ignored; alu_valid=0 the next cycle,
//   abandoning any multicycle op. Tolerates a flush arriving in any state.
//  resetn low mid-BUSY: same as reset; no out_valid is ever produced for the
//   aborted op.
//  Ops leave in push order; none is duplicated or dropped except by flush/reset.
// TESTING
//  ADD a=5 b=7 tag=3x, out_ready=1 -> out_valid 2 cycles after push,
//   out_result=12, tag=3; alu_valid high exactly 1 cycle.
//  MULT a=6 b=7, ALU model bubble=1 for 3 BUSY cycles -> alu_valid high 4 cycles,
//   alu_a/alu_b stable, single out_result=42.
//  out_ready=0 for 6 cycles with in_valid=1 tags 1,2,3 -> in_ready=0 once 2
//   buffered; op3 held; on release outputs tags 1,2,3 in order, none lost.
//  DIV b=0 (bubble stays 0) -> result 0xFFFF_FFFF_FFFF_FFFF in 1 BUSY cycle;
//   choose=1 SLL a=1 b=31 -> out_result 0xFFFF_FFFF_8000_0000.
//  flush in BUSY of DIV with 1 queued -> next cycle IDLE, count 0, alu_valid 0;
//   next new op completes correctly; no stale out_valid.
//  resetn=0 one cycle mid-BUSY and in DONE with out_ready=0 -> all outputs at
//   reset values next cycle; in_ready=1 after resetn returns high.

Source files
------------

// File: rtl/exe_issue.sv
// Issue stage: 2-entry op buffer feeding the execute ALU, holding operands
// across ALU bubbles and returning the captured result on a valid/ready port.
module exe_issue #(
  parameter int FUNC_W = 5,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       in_a,
  input  logic [63:0]       in_b,
  input  logic [FUNC_W-1:0] in_func,
  input  logic              in_choose,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [63:0]       alu_a,
  output logic [63:0]       alu_b,
  output logic [FUNC_W-1:0] alu_func,
  output logic              alu_choose,
  output logic              alu_valid,
  input  logic              alu_bubble,
  input  logic [63:0]       alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_result,
  output logic [TAG_W-1:0]  out_tag
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [63:0]       out_result_q;
  logic [TAG_W-1:0]  out_tag_q;

  logic [63:0]       fa_q      [2];
  logic [63:0]       fb_q      [2];
  logic [FUNC_W-1:0] ffunc_q   [2];
  logic              fchoose_q [2];
  logic [TAG_W-1:0]  ftag_q    [2];

  logic push;
  logic pop;

  assign in_ready = resetn && (count_q != 2'd2);
  assign push     = in_valid && in_ready && !flush;
  // A flushed op must never land in the output register.
  assign pop      = (state_q == BUSY) && !alu_bubble && !flush;

  assign alu_a      = fa_q[rd_ptr_q];
  assign alu_b      = fb_q[rd_ptr_q];
  assign alu_func   = ffunc_q[rd_ptr_q];
  assign alu_choose = fchoose_q[rd_ptr_q];
  assign alu_valid  = (state_q == BUSY);

  assign out_valid  = (state_q == DONE);
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Decisions look at the post-push count so a fresh op starts next cycle.
    case (state_q)
      IDLE:    if (count_d != 2'd0) state_d = BUSY;
      BUSY:    if (pop) state_d = DONE;
      DONE:    if (out_ready) state_d = (count_d != 2'd0) ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      out_result_q <= 64'd0;
      out_tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (pop) begin
        out_result_q <= alu_result;
        out_tag_q    <= ftag_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wr_ptr_q]      <= in_a;
      fb_q[wr_ptr_q]      <= in_b;
      ffunc_q[wr_ptr_q]   <= in_func;
      fchoose_q[wr_ptr_q] <= in_choose;
      ftag_q[wr_ptr_q]    <= in_tag;
    end
  end

endmodule

// File: tb/tb_exe_issue.sv
// Scoreboard bench for exe_issue with a small behavioural ALU (ADD/SLL/MULT/DIV,
// MULT and nonzero-divisor DIV stall for three bubble cycles).
module tb_exe_issue;

  localparam logic [4:0] F_ADD  = 5'd0;
  localparam logic [4:0] F_SLL  = 5'd1;
  localparam logic [4:0] F_MULT = 5'd2;
  localparam logic [4:0] F_DIV  = 5'd3;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, in_choose;
  logic [63:0] in_a, in_b, alu_a, alu_b, alu_result, out_result;
  logic [4:0]  in_func, alu_func;
  logic [7:0]  in_tag, out_tag;
  logic        alu_choose, alu_valid, alu_bubble, out_valid, out_ready;

  typedef struct packed {
    logic [63:0] res;
    logic [7:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   bub_cnt  = 0;

  exe_issue #(.FUNC_W(5), .TAG_W(8)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_func(in_func), .in_choose(in_choose), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_choose(alu_choose),
    .alu_valid(alu_valid), .alu_bubble(alu_bubble), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  logic [63:0] r64;
  logic [31:0] r32;
  always_comb begin
    r64 = 64'd0;
    r32 = 32'd0;
    case (alu_func)
      F_ADD:  begin r64 = alu_a + alu_b; r32 = alu_a[31:0] + alu_b[31:0]; end
      F_SLL:  begin r64 = alu_a << alu_b[5:0]; r32 = alu_a[31:0] << alu_b[4:0]; end
      F_MULT: begin r64 = alu_a * alu_b; r32 = alu_a[31:0] * alu_b[31:0]; end
      F_DIV: begin
        r64 = (alu_b == 64'd0) ? '1 : alu_a / alu_b;
        r32 = (alu_b[31:0] == 32'd0) ? '1 : alu_a[31:0] / alu_b[31:0];
      end
      default: ;
    endcase
    alu_result = alu_choose ? {{32{r32[31]}}, r32} : r64;
  end

  assign alu_bubble = alu_valid && (bub_cnt < 3) &&
                      ((alu_func == F_MULT) || (alu_func == F_DIV && alu_b != 64'd0));

  always @(posedge clk) begin
    if (!alu_valid) bub_cnt <= 0;
    else if (alu_bubble) bub_cnt <= bub_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got tag %0d result %h expected no output", out_tag, out_result);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_result", out_result, mon_e.res);
        check("out_tag", {56'd0, out_tag}, {56'd0, mon_e.tag});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [63:0] a, input logic [63:0] b, input logic [4:0] f,
                         input logic ch, input logic [7:0] tg,
                         input logic expect_it, input logic [63:0] res);
    int waited = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_func = f; in_choose = ch; in_tag = tg;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 for tag %0d", tg);
    end else if (expect_it) begin
      exp_q.push_back('{res: res, tag: tg});
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic count_busy(output int n, output logic stable);
    logic [63:0] la, lb;
    la = alu_a; lb = alu_b; n = 0; stable = 1'b1;
    while (alu_valid && n < 50) begin
      if (alu_a !== la || alu_b !== lb) stable = 1'b0;
      n++;
      tick();
    end
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      tick();
      waited++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  int   nb;
  logic stab;

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_func = '0; in_choose = 1'b0; in_tag = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_alu_valid", 64'(alu_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    resetn = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    tick();

    // ADD: out_valid two cycles after the push, alu_valid exactly one cycle
    push_op(64'd5, 64'd7, F_ADD, 1'b0, 8'h3, 1'b1, 64'd12);
    check("add_alu_valid_c1", 64'(alu_valid), 64'd1);
    check("add_out_valid_c1", 64'(out_valid), 64'd0);
    tick();
    check("add_alu_valid_c2", 64'(alu_valid), 64'd0);
    check("add_out_valid_c2", 64'(out_valid), 64'd1);
    tick();
    check("add_out_valid_c3", 64'(out_valid), 64'd0);

    // MULT with three bubble cycles
    push_op(64'd6, 64'd7, F_MULT, 1'b0, 8'h21, 1'b1, 64'd42);
    count_busy(nb, stab);
    check("mult_busy_cycles", 64'(nb), 64'd4);
    check("mult_operands_stable", 64'(stab), 64'd1);
    check("mult_out_valid", 64'(out_valid), 64'd1);
    drain();

    // Backpressure: three ops fill the path, a fourth waits
    out_ready = 1'b0;
    push_op(64'd1, 64'd1, F_ADD, 1'b0, 8'd1, 1'b1, 64'd2);
    push_op(64'd2, 64'd2, F_ADD, 1'b0, 8'd2, 1'b1, 64'd4);
    push_op(64'd3, 64'd3, F_ADD, 1'b0, 8'd3, 1'b1, 64'd6);
    in_valid = 1'b1; in_a = 64'd4; in_b = 64'd4; in_func = F_ADD; in_choose = 1'b0; in_tag = 8'd4;
    for (int i = 0; i < 6; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_tag_held", 64'(out_tag), 64'd1);
      tick();
    end
    check("bp_out_valid_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    push_op(64'd4, 64'd4, F_ADD, 1'b0, 8'd4, 1'b1, 64'd8);
    drain();

    // DIV by zero completes in one BUSY cycle; 32-bit SLL sign-extends
    push_op(64'd100, 64'd0, F_DIV, 1'b0, 8'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    count_busy(nb, stab);
    check("div0_busy_cycles", 64'(nb), 64'd1);
    push_op(64'd1, 64'd31, F_SLL, 1'b1, 8'd6, 1'b1, 64'hFFFF_FFFF_8000_0000);
    drain();

    // Flush during a stalled DIV with one op queued; same-cycle push ignored
    push_op(64'd50, 64'd5, F_DIV, 1'b0, 8'd7, 1'b0, 64'd0);
    push_op(64'd8, 64'd8, F_ADD, 1'b0, 8'd8, 1'b0, 64'd0);
    check("fl_pre_alu_valid", 64'(alu_valid), 64'd1);
    flush = 1'b1;
    in_valid = 1'b1; in_a = 64'd9; in_b = 64'd9; in_func = F_ADD; in_tag = 8'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_alu_valid", 64'(alu_valid), 64'd0);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("fl_stays_idle", 64'(alu_valid), 64'd0);
    push_op(64'd10, 64'd20, F_ADD, 1'b0, 8'd10, 1'b1, 64'd30);
    drain();

    // Reset mid-BUSY aborts the op
    push_op(64'd3, 64'd4, F_MULT, 1'b0, 8'd11, 1'b0, 64'd0);
    resetn = 1'b0;
    tick();
    check("rb_in_ready", 64'(in_ready), 64'd0);
    check("rb_alu_valid", 64'(alu_valid), 64'd0);
    check("rb_out_valid", 64'(out_valid), 64'd0);
    check("rb_out_result", out_result, 64'd0);
    check("rb_out_tag", 64'(out_tag), 64'd0);
    resetn = 1'b1;
    #1;
    check("rb_in_ready_after", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rb_no_out_valid", 64'(out_valid), 64'd0);
    end

    // Reset while a result waits in DONE
    out_ready = 1'b0;
    push_op(64'd1, 64'd2, F_ADD, 1'b0, 8'd12, 1'b0, 64'd0);
    tick();
    check("rd_out_valid_pre", 64'(out_valid), 64'd1);
    check("rd_out_result_pre", out_result, 64'd3);
    resetn = 1'b0;
    tick();
    check("rd_out_valid", 64'(out_valid), 64'd0);
    check("rd_out_result", out_result, 64'd0);
    check("rd_out_tag", 64'(out_tag), 64'd0);
    check("rd_alu_valid", 64'(alu_valid), 64'd0);
    check("rd_in_ready", 64'(in_ready), 64'd0);
    resetn = 1'b1;
    out_ready = 1'b1;
    tick();
    check("rd_in_ready_after", 64'(in_ready), 64'd1);
    push_op(64'd3, 64'd4, F_SLL, 1'b0, 8'd13, 1'b1, 64'd48);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
